// File: rtl/rob_pkg.sv
// Shared sizing constants and types for the ROB bypass controller.
package rob_pkg;
  localparam int NUM_REGISTERS     = 8;
  localparam int LOG_NUM_REGISTERS = 3;
  localparam int ROB_ENTRIES       = 8;
  localparam int LOG_ROB_ENTRIES   = 3;

  typedef logic [LOG_NUM_REGISTERS-1:0] reg_idx_t;
  typedef logic [LOG_ROB_ENTRIES-1:0]   rob_tag_t;
  typedef logic [LOG_ROB_ENTRIES:0]     rob_cnt_t;

  localparam rob_cnt_t ROB_FULL = rob_cnt_t'(ROB_ENTRIES);

  // What the ROB remembers per entry so a commit can find its rename-table slot.
  typedef struct packed {
    logic     has_dest;
    reg_idx_t dest;
  } rob_entry_t;
endpackage

// File: rtl/rob_bypass_ctrl_if.sv
// Decode/commit handshake and rename-table port bundle for rob_bypass_ctrl.
interface rob_bypass_ctrl_if;
  import rob_pkg::*;

  logic     flush;
  logic     alloc_valid;
  logic     alloc_has_dest;
  reg_idx_t alloc_dest;
  logic     alloc_ready;
  rob_tag_t alloc_tag;
  logic     commit_valid;
  logic     lookup_valid;
  logic     lookup_ready;
  reg_idx_t src_a;
  reg_idx_t src_b;
  logic     a_pending;
  logic     b_pending;
  rob_tag_t a_tag;
  rob_tag_t b_tag;
  rob_cnt_t rob_count;
  reg_idx_t rf_ra;
  reg_idx_t rf_rb;
  rob_tag_t rf_a;
  rob_tag_t rf_b;
  rob_tag_t rf_d;
  reg_idx_t rf_writeAddr;
  logic     rf_writeEnable;

  modport slave (
    input  flush, alloc_valid, alloc_has_dest, alloc_dest, commit_valid,
           lookup_valid, src_a, src_b, rf_a, rf_b,
    output alloc_ready, alloc_tag, lookup_ready, a_pending, b_pending,
           a_tag, b_tag, rob_count, rf_ra, rf_rb, rf_d, rf_writeAddr,
           rf_writeEnable
  );

  modport master (
    output flush, alloc_valid, alloc_has_dest, alloc_dest, commit_valid,
           lookup_valid, src_a, src_b, rf_a, rf_b,
    input  alloc_ready, alloc_tag, lookup_ready, a_pending, b_pending,
           a_tag, b_tag, rob_count, rf_ra, rf_rb, rf_d, rf_writeAddr,
           rf_writeEnable
  );
endinterface

// File: rtl/rob_circ_ptr.sv
// Circular pointer: increments modulo 2**WIDTH, synchronous clear wins over increment.
module rob_circ_ptr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] ptr
);
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ptr <= '0;
    else if (clear) ptr <= '0;
    else if (inc)   ptr <= ptr + WIDTH'(1);
  end
endmodule

// File: rtl/rob_bypass_ctrl.sv
// Rename-table sequencer: in-order ROB tag allocation/retirement, per-register
// pending bits, and zero-latency source lookups through the external table.
module rob_bypass_ctrl
  import rob_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rob_bypass_ctrl_if.slave   bus
);
  rob_tag_t                 head;
  rob_tag_t                 tail;
  rob_cnt_t                 count;
  logic [NUM_REGISTERS-1:0] pend;
  logic [NUM_REGISTERS-1:0] pend_next;
  rob_entry_t               rob_q [ROB_ENTRIES];
  rob_entry_t               head_entry;

  logic not_full, not_empty;
  logic alloc_accept, commit_accept;
  logic steal, set_pend, clear_pend;

  assign head_entry = rob_q[head];
  assign not_full   = (count != ROB_FULL);
  assign not_empty  = (count != '0);

  // Reset gating keeps the write port quiet while reset is held mid-cycle.
  assign alloc_accept  = reset && !bus.flush && bus.alloc_valid && not_full;
  assign commit_accept = reset && !bus.flush && bus.commit_valid && not_empty;
  assign steal         = commit_accept && head_entry.has_dest;
  assign set_pend      = alloc_accept && bus.alloc_has_dest;
  // A younger writer to the same register leaves a different tag in the table.
  assign clear_pend    = steal && (bus.rf_b == head);

  assign bus.alloc_ready    = not_full && !bus.flush;
  assign bus.alloc_tag      = tail;
  assign bus.rob_count      = count;
  assign bus.rf_writeEnable = set_pend;
  assign bus.rf_writeAddr   = bus.alloc_dest;
  assign bus.rf_d           = tail;
  assign bus.rf_ra          = bus.src_a;
  assign bus.rf_rb          = steal ? head_entry.dest : bus.src_b;
  assign bus.lookup_ready   = bus.lookup_valid && !steal;
  assign bus.a_pending      = pend[bus.src_a];
  assign bus.a_tag          = bus.rf_a;
  assign bus.b_pending      = pend[bus.src_b];
  assign bus.b_tag          = bus.rf_b;

  always_comb begin
    // NOTE: defaulting every comb output first guarantees no latch is inferred.
    pend_next = pend;
    if (clear_pend) pend_next[head_entry.dest] = 1'b0;
    // Applied after the clear so a same-register allocation keeps the bit set.
    if (set_pend)   pend_next[bus.alloc_dest]  = 1'b1;
  end

  rob_circ_ptr #(.WIDTH(LOG_ROB_ENTRIES)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_accept),
    .clear (bus.flush),
    .ptr   (head)
  );

  rob_circ_ptr #(.WIDTH(LOG_ROB_ENTRIES)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc_accept),
    .clear (bus.flush),
    .ptr   (tail)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             count <= '0;
    else if (bus.flush)                     count <= '0;
    else if (alloc_accept && !commit_accept) count <= count + rob_cnt_t'(1);
    else if (commit_accept && !alloc_accept) count <= count - rob_cnt_t'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pend <= '0;
    else if (bus.flush) pend <= '0;
    else                pend <= pend_next;
  end

  // NOTE: this small array is reset because commit reads has_dest of the head
  // entry, and an unknown value there would corrupt the pending bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_ENTRIES; i++) rob_q[i] <= '0;
    end else if (alloc_accept) begin
      rob_q[tail] <= '{has_dest: bus.alloc_has_dest, dest: bus.alloc_dest};
    end
  end
endmodule
